butterfly_stage_hs: RTL and testbench

Next-generation butterfly stage for the matrix-transpose network. It adds a parametrised pairing stride, so one module covers every stage of a Benes/butterfly network. It adds a valid/ready handshake with a 2-entry output skid buffer, so backpressure propagates stage-to-stage without combinational ready chains. Switch controls are captured together with their data beat.

---
 rtl/mt_pkg.sv | 21 ++
 rtl/hs_skid_buffer.sv | 53 +++++
 rtl/switch_2_2.sv | 15 +
 rtl/butterfly_stage_hs.sv | 60 ++++++
 tb/tb_butterfly_stage_hs.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mt_pkg.sv
// Shared helpers for the matrix-transpose butterfly network: switch pairing
// arithmetic and parameter sanity functions.
package mt_pkg;

  localparam int DEFAULT_NUM_INPUTS = 16;
  localparam int DEFAULT_NUM_STAGES = $clog2(DEFAULT_NUM_INPUTS);

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic int num_stages(input int num_inputs);
    return $clog2(num_inputs);
  endfunction

  // Switch k sits in block k/stride; its low leg is offset k%stride in that block.
  function automatic int stride_lo(input int k, input int stride);
    return (k / stride) * 2 * stride + (k % stride);
  endfunction

endpackage

// File: rtl/hs_skid_buffer.sv
// Generic 2-entry valid/ready buffer; ready is decoded from the occupancy
// register so it never depends combinationally on out_rdy.
module hs_skid_buffer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic [1:0]       occ;
  logic             push;
  logic             pop;

  assign in_rdy    = (occ != 2'd2);
  assign out_val   = (occ != 2'd0);
  assign push      = in_val && in_rdy;
  assign pop       = out_val && out_rdy;
  assign out_data  = head;
  assign occupancy = occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= in_data;
          else             tail <= in_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        // Simultaneous push/pop only happens at occupancy 1: head is replaced.
        2'b11: head <= in_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/switch_2_2.sv
// 2x2 crossbar cell: pass (sel = 0) or swap (sel = 1) two elements.
module switch_2_2 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] in_lo,
  input  logic [WIDTH-1:0] in_hi,
  input  logic             sel,
  output logic [WIDTH-1:0] out_lo,
  output logic [WIDTH-1:0] out_hi
);

  assign out_lo = sel ? in_hi : in_lo;
  assign out_hi = sel ? in_lo : in_hi;

endmodule

// File: rtl/butterfly_stage_hs.sv
// One butterfly/Benes stage with configurable pairing stride and a 2-entry
// output skid buffer; the permuted vector is captured together with its beat.
module butterfly_stage_hs
  import mt_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_INPUTS = 16,
  parameter int STRIDE     = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_val,
  output logic                                   in_rdy,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  input_elements,
  input  logic [NUM_INPUTS/2-1:0]                ctrls,
  output logic                                   out_val,
  input  logic                                   out_rdy,
  output logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  output_elements,
  output logic [1:0]                             occupancy
);

  localparam int NUM_SWITCHES = NUM_INPUTS / 2;

  if (!is_pow2(NUM_INPUTS) || NUM_INPUTS < 2) begin : g_bad_inputs
    $error("butterfly_stage_hs: NUM_INPUTS must be a power of 2 and >= 2");
  end
  if (!is_pow2(STRIDE) || STRIDE < 1 || STRIDE > NUM_INPUTS / 2) begin : g_bad_stride
    $error("butterfly_stage_hs: STRIDE must be a power of 2 in 1..NUM_INPUTS/2");
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("butterfly_stage_hs: DATA_WIDTH must be >= 1");
  end

  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] permuted;

  for (genvar k = 0; k < NUM_SWITCHES; k++) begin : g_sw
    localparam int LO = stride_lo(k, STRIDE);
    localparam int HI = LO + STRIDE;
    switch_2_2 #(.WIDTH(DATA_WIDTH)) u_sw (
      .in_lo  (input_elements[LO]),
      .in_hi  (input_elements[HI]),
      .sel    (ctrls[k]),
      .out_lo (permuted[LO]),
      .out_hi (permuted[HI])
    );
  end

  hs_skid_buffer #(.WIDTH(DATA_WIDTH * NUM_INPUTS)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_data   (permuted),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_data  (output_elements),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_butterfly_stage_hs.sv
// Scoreboard bench: three 8-element stages (STRIDE 1, 2, 4) share one
// stimulus stream; a monitor checks each against a permutation model.
module tb_butterfly_stage_hs;

  localparam int W = 16;
  localparam int N = 8;
  typedef logic [N*W-1:0] vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_val = 1'b0;
  logic       out_rdy = 1'b0;
  logic [3:0] ctrls = 4'h0;
  vec_t       in_vec = '0;

  logic       in_rdy_a  [3];
  logic       out_val_a [3];
  vec_t       out_a     [3];
  logic [1:0] occ_a     [3];

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   occ_m  [3];
  bit   hold_v [3];
  vec_t hold_d [3];
  vec_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  butterfly_stage_hs #(.DATA_WIDTH(W), .NUM_INPUTS(N), .STRIDE(1)) u_s1 (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy_a[0]),
    .input_elements(in_vec), .ctrls(ctrls), .out_val(out_val_a[0]),
    .out_rdy(out_rdy), .output_elements(out_a[0]), .occupancy(occ_a[0]));
  butterfly_stage_hs #(.DATA_WIDTH(W), .NUM_INPUTS(N), .STRIDE(2)) u_s2 (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy_a[1]),
    .input_elements(in_vec), .ctrls(ctrls), .out_val(out_val_a[1]),
    .out_rdy(out_rdy), .output_elements(out_a[1]), .occupancy(occ_a[1]));
  butterfly_stage_hs #(.DATA_WIDTH(W), .NUM_INPUTS(N), .STRIDE(4)) u_s4 (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy_a[2]),
    .input_elements(in_vec), .ctrls(ctrls), .out_val(out_val_a[2]),
    .out_rdy(out_rdy), .output_elements(out_a[2]), .occupancy(occ_a[2]));

  task automatic check(input bit ok, input string name, input vec_t act, input vec_t exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Element i pairs with element i^s; its switch index counts pairs in order.
  function automatic vec_t model(input vec_t in, input logic [3:0] c, input int s);
    vec_t r;
    int sw, src;
    r = '0;
    for (int i = 0; i < N; i++) begin
      sw  = (i / (2 * s)) * s + (i % s);
      src = c[sw] ? (i ^ s) : i;
      r[i*W +: W] = in[src*W +: W];
    end
    return r;
  endfunction

  function automatic vec_t from_list(input int e [N]);
    vec_t r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(e[i]);
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom);
    return r;
  endfunction

  task automatic push_exp();
    q0.push_back(model(in_vec, ctrls, 1));
    q1.push_back(model(in_vec, ctrls, 2));
    q2.push_back(model(in_vec, ctrls, 4));
  endtask

  task automatic pop_exp(input int id, output vec_t v, output bit ok);
    ok = 1'b1;
    v  = '0;
    case (id)
      0: if (q0.size() != 0) v = q0.pop_front(); else ok = 1'b0;
      1: if (q1.size() != 0) v = q1.pop_front(); else ok = 1'b0;
      default: if (q2.size() != 0) v = q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  task automatic mon_inst(input int id);
    vec_t exp;
    bit   have;
    bit   p, q;
    check(occ_a[id] == 2'(occ_m[id]), "occupancy", vec_t'(occ_a[id]), vec_t'(occ_m[id]));
    check(out_val_a[id] == (occ_m[id] != 0), "out_val", vec_t'(out_val_a[id]), vec_t'(occ_m[id] != 0));
    check(in_rdy_a[id] == (occ_m[id] < 2), "in_rdy", vec_t'(in_rdy_a[id]), vec_t'(occ_m[id] < 2));
    if (hold_v[id])
      check(out_val_a[id] && out_a[id] == hold_d[id], "hold_stable", out_a[id], hold_d[id]);
    if (out_val_a[id] && out_rdy) begin
      pop_exp(id, exp, have);
      if (!have) check(1'b0, "unexpected_beat", out_a[id], '0);
      else       check(out_a[id] == exp, "beat_data", out_a[id], exp);
    end
    hold_v[id] = out_val_a[id] && !out_rdy;
    hold_d[id] = out_a[id];
    p = in_val && (occ_m[id] < 2);
    q = (occ_m[id] != 0) && out_rdy;
    occ_m[id] = occ_m[id] + int'(p) - int'(q);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int id = 0; id < 3; id++) mon_inst(id);
    end
  end

  task automatic reset_model();
    q0.delete(); q1.delete(); q2.delete();
    for (int id = 0; id < 3; id++) begin
      occ_m[id]  = 0;
      hold_v[id] = 1'b0;
    end
  endtask

  // Offer one beat for one cycle; returns with inputs idle at posedge+1.
  task automatic drive_beat(input vec_t v, input logic [3:0] c, output bit taken);
    in_vec = v;
    ctrls  = c;
    in_val = 1'b1;
    @(negedge clk);
    taken = in_rdy_a[0];
    if (taken) push_exp();
    @(posedge clk);
    #1;
    in_val = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    for (int id = 0; id < 3; id++) begin
      check(out_val_a[id] == 1'b0, {tag, "_out_val"}, vec_t'(out_val_a[id]), '0);
      check(occ_a[id] == 2'd0, {tag, "_occupancy"}, vec_t'(occ_a[id]), '0);
      check(out_a[id] == '0, {tag, "_data"}, out_a[id], '0);
    end
  endtask

  initial begin
    bit   taken;
    int   e [N];
    vec_t va, vb, vc;
    int   acc, cyc;

    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;
    #1;
    check(in_rdy_a[0] && in_rdy_a[1] && in_rdy_a[2], "in_rdy_after_reset", vec_t'(in_rdy_a[0]), 1);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Backpressure: A and B fill the buffer, C is refused until a pop.
    va = rand_vec(); vb = rand_vec(); vc = rand_vec();
    out_rdy = 1'b0;
    drive_beat(va, 4'h3, taken);
    check(taken, "bp_accept_a", vec_t'(taken), 1);
    drive_beat(vb, 4'h5, taken);
    check(taken, "bp_accept_b", vec_t'(taken), 1);
    drive_beat(vc, 4'ha, taken);
    check(!taken, "bp_refuse_c", vec_t'(taken), 0);
    check(occ_a[1] == 2'd2 && !in_rdy_a[1], "bp_full", vec_t'(occ_a[1]), 2);
    out_rdy = 1'b1;
    taken = 1'b0;
    for (int i = 0; i < 5 && !taken; i++) drive_beat(vc, 4'ha, taken);
    check(taken, "bp_accept_c", vec_t'(taken), 1);
    repeat (4) @(posedge clk);
    #1;
    check(q1.size() == 0, "bp_drained", vec_t'(q1.size()), 0);

    // Asynchronous reset mid-cycle with two beats buffered.
    out_rdy = 1'b0;
    drive_beat(rand_vec(), 4'h1, taken);
    drive_beat(rand_vec(), 4'h2, taken);
    check(occ_a[0] == 2'd2, "pre_reset_full", vec_t'(occ_a[0]), 2);
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_state("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    reset_model();
    #1;
    check(in_rdy_a[2] == 1'b1, "in_rdy_after_midreset", vec_t'(in_rdy_a[2]), 1);
    mon_en = 1'b1;
    out_rdy = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Directed permutation checks.
    for (int i = 0; i < N; i++) in_vec[i*W +: W] = W'(10 + i);
    drive_beat(in_vec, 4'b0101, taken);
    e = '{12, 11, 10, 13, 16, 15, 14, 17};
    check(out_val_a[1] && out_a[1] == from_list(e), "perm_stride2", out_a[1], from_list(e));
    for (int i = 0; i < N; i++) in_vec[i*W +: W] = W'(i);
    drive_beat(in_vec, 4'hf, taken);
    e = '{1, 0, 3, 2, 5, 4, 7, 6};
    check(out_val_a[0] && out_a[0] == from_list(e), "perm_stride1_cross", out_a[0], from_list(e));
    e = '{4, 5, 6, 7, 0, 1, 2, 3};
    check(out_val_a[2] && out_a[2] == from_list(e), "perm_stride4_cross", out_a[2], from_list(e));
    @(posedge clk);
    #1;

    // Streaming at full rate: occupancy settles at 1.
    out_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive_beat(rand_vec(), 4'($urandom), taken);
      if (!taken || occ_a[1] != 2'd1) check(1'b0, "stream_rate", vec_t'(occ_a[1]), 1);
    end
    check(taken && occ_a[1] == 2'd1, "stream_steady", vec_t'(occ_a[1]), 1);
    @(posedge clk);
    #1;

    // Random valid/ready traffic.
    acc = 0;
    cyc = 0;
    while (acc < 10000 && cyc < 40000) begin
      in_val  = ($urandom_range(3) != 0);
      out_rdy = ($urandom_range(3) != 0);
      in_vec  = rand_vec();
      ctrls   = 4'($urandom);
      @(negedge clk);
      if (in_val && in_rdy_a[0]) begin
        push_exp();
        acc++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check(acc == 10000, "random_beats_accepted", vec_t'(acc), 10000);

    in_val  = 1'b0;
    out_rdy = 1'b1;
    cyc = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check(q0.size() == 0 && q1.size() == 0 && q2.size() == 0, "final_drain",
          vec_t'(q0.size() + q1.size() + q2.size()), 0);
    @(posedge clk);
    #1;
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
